// File: rtl/single_accumulator.sv
// single_accumulator
//   Sums N_TERMS consecutive IEEE-754 single-precision products (from
//   single_multiplier) into a running sum, rounding to nearest-even after
//   every addition, then presents the sum on a stb/ack output and clears.
//   Iterative datapath: one adder, one-cycle alignment shifter and one-cycle
//   leading-zero normaliser, sequenced by an FSM.
//
//   Optional feature macro: SINGLE_ACC_LAST_EN adds input_a_last, which
//   ends the accumulation early after the flagged term.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-low reset
//   input_a       in   32-bit product operand
//   input_a_stb   in   input_a valid
//   input_a_ack   out  ready to take input_a
//   input_a_last  in   (SINGLE_ACC_LAST_EN only) term closes the accumulation
//   output_z      out  32-bit accumulated sum
//   output_z_stb  out  output_z valid
//   output_z_ack  in   consumer has taken output_z
module single_accumulator #(
    parameter int N_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
`ifdef SINGLE_ACC_LAST_EN
    input  logic        input_a_last,
`endif
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

    typedef enum logic [3:0] {
        GET_A, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT_Z
    } state_t;

    state_t             r_state;
    logic [31:0]        r_sum;
    logic [31:0]        r_a;
    logic [CW-1:0]      r_count;
`ifdef SINGLE_ACC_LAST_EN
    logic               r_last;
`endif

    // unpacked operands (biased exponents, hidden bit explicit)
    logic               r_s_sign, r_a_sign;
    logic signed [9:0]  r_s_exp, r_a_exp;
    logic [23:0]        r_s_man, r_a_man;

    // datapath: mantissas carry guard/round/sticky in bits [2:0]
    logic [26:0]        r_big_m, r_small_m;
    logic [27:0]        r_m;
    logic signed [9:0]  r_exp;
    logic               r_sign, r_sub, r_zero;
    logic [22:0]        r_frac;
    logic               r_special;
    logic [31:0]        r_res;

    logic               w_s_nan, w_a_nan, w_s_inf, w_a_inf;
    logic               w_special;
    logic [31:0]        w_special_res;
    logic               w_a_bigger;
    logic signed [9:0]  w_big_exp, w_small_exp;
    logic [23:0]        w_big_man, w_small_man;
    logic               w_big_sign;
    logic [9:0]         w_diff;
    logic [26:0]        w_small_ext, w_mask, w_aligned;
    logic [27:0]        w_addsub;
    logic [4:0]         w_lz;
    logic               w_rnd_up;
    logic [24:0]        w_man25;
    logic               w_end;

    always_comb begin
        w_s_nan = (&r_sum[30:23]) && (|r_sum[22:0]);
        w_a_nan = (&r_a[30:23])   && (|r_a[22:0]);
        w_s_inf = (&r_sum[30:23]) && !(|r_sum[22:0]);
        w_a_inf = (&r_a[30:23])   && !(|r_a[22:0]);

        w_special     = 1'b1;
        w_special_res = 32'h7FC00000;
        if (w_s_nan || w_a_nan) begin
            w_special_res = 32'h7FC00000;
        end else if (w_s_inf && w_a_inf && (r_sum[31] != r_a[31])) begin
            w_special_res = 32'h7FC00000;
        end else if (w_s_inf) begin
            w_special_res = r_sum;
        end else if (w_a_inf) begin
            w_special_res = r_a;
        end else begin
            w_special = 1'b0;
        end

        // Zeros carry exponent 0 and mantissa 0, so they always lose this
        // comparison against a non-zero operand and add through exactly.
        w_a_bigger  = (r_a_exp > r_s_exp) ||
                      ((r_a_exp == r_s_exp) && (r_a_man > r_s_man));
        w_big_exp   = w_a_bigger ? r_a_exp  : r_s_exp;
        w_small_exp = w_a_bigger ? r_s_exp  : r_a_exp;
        w_big_man   = w_a_bigger ? r_a_man  : r_s_man;
        w_small_man = w_a_bigger ? r_s_man  : r_a_man;
        w_big_sign  = w_a_bigger ? r_a_sign : r_s_sign;
        w_diff      = w_big_exp - w_small_exp;
        w_small_ext = {w_small_man, 3'b000};

        w_mask = '0;
        if (w_diff > 10'd26) begin
            w_aligned = {26'd0, |w_small_ext};
        end else begin
            w_mask    = (27'd1 << w_diff[4:0]) - 27'd1;
            w_aligned = (w_small_ext >> w_diff[4:0]) |
                        {26'd0, |(w_small_ext & w_mask)};
        end

        w_addsub = r_sub ? ({1'b0, r_big_m} - {1'b0, r_small_m})
                         : ({1'b0, r_big_m} + {1'b0, r_small_m});

        // ascending scan: the highest set bit is the last one to write
        w_lz = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (r_m[i]) w_lz = 5'(26 - i);
        end

        w_rnd_up = r_m[2] && (r_m[1] || r_m[0] || r_m[3]);
        w_man25  = {1'b0, r_m[26:3]} + {24'd0, w_rnd_up};
    end

`ifdef SINGLE_ACC_LAST_EN
    assign w_end = (r_count == LAST_CNT) || r_last;
`else
    assign w_end = (r_count == LAST_CNT);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= GET_A;
            r_sum        <= '0;
            r_count      <= '0;
            input_a_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= '0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        r_a         <= input_a;
`ifdef SINGLE_ACC_LAST_EN
                        r_last      <= input_a_last;
`endif
                        input_a_ack <= 1'b0;
                        r_state     <= UNPACK;
                    end else begin
                        input_a_ack <= 1'b1;
                    end
                end
                UNPACK: begin
                    r_s_sign <= r_sum[31];
                    r_a_sign <= r_a[31];
                    // denormals flush to signed zero
                    r_s_exp  <= (r_sum[30:23] == 8'd0) ? 10'sd0 : $signed({2'b00, r_sum[30:23]});
                    r_a_exp  <= (r_a[30:23] == 8'd0)   ? 10'sd0 : $signed({2'b00, r_a[30:23]});
                    r_s_man  <= (r_sum[30:23] == 8'd0) ? 24'd0 : {1'b1, r_sum[22:0]};
                    r_a_man  <= (r_a[30:23] == 8'd0)   ? 24'd0 : {1'b1, r_a[22:0]};
                    r_state  <= SPECIAL;
                end
                SPECIAL: begin
                    r_special <= w_special;
                    r_res     <= w_special_res;
                    r_state   <= w_special ? PACK : ALIGN;
                end
                ALIGN: begin
                    r_big_m   <= {w_big_man, 3'b000};
                    r_small_m <= w_aligned;
                    r_exp     <= w_big_exp;
                    r_sign    <= w_big_sign;
                    r_sub     <= r_s_sign ^ r_a_sign;
                    r_state   <= ADD;
                end
                ADD: begin
                    r_m     <= w_addsub;
                    r_zero  <= (w_addsub == 28'd0);
                    r_state <= NORM;
                end
                NORM: begin
                    if (r_m[27]) begin
                        r_m   <= {1'b0, r_m[27:2], r_m[1] | r_m[0]};
                        r_exp <= r_exp + 10'sd1;
                    end else if (r_m[26:0] != 27'd0) begin
                        r_m   <= r_m << w_lz;
                        r_exp <= r_exp - 10'(w_lz);
                    end
                    r_state <= ROUND;
                end
                ROUND: begin
                    // on mantissa carry the value is exactly 1.0 x 2^(exp+1)
                    r_frac <= w_man25[24] ? w_man25[23:1] : w_man25[22:0];
                    if (w_man25[24]) r_exp <= r_exp + 10'sd1;
                    r_state <= PACK;
                end
                PACK: begin
                    if (r_special) begin
                        r_sum <= r_res;
                    end else if (r_zero) begin
                        // same-sign exact zero only arises from (-0)+(-0) or (+0)+(+0)
                        r_sum <= {r_sign & ~r_sub, 31'd0};
                    end else if (r_exp >= 10'sd255) begin
                        r_sum <= {r_sign, 8'hFF, 23'd0};
                    end else if (r_exp <= 10'sd0) begin
                        r_sum <= {r_sign, 31'd0};
                    end else begin
                        r_sum <= {r_sign, r_exp[7:0], r_frac};
                    end
                    if (w_end) begin
                        r_state <= PUT_Z;
                    end else begin
                        r_count     <= r_count + 1'b1;
                        input_a_ack <= 1'b1;
                        r_state     <= GET_A;
                    end
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        r_sum        <= '0;
                        r_count      <= '0;
                        input_a_ack  <= 1'b1;
                        r_state      <= GET_A;
                    end else begin
                        output_z     <= r_sum;
                        output_z_stb <= 1'b1;
                    end
                end
                default: r_state <= GET_A;
            endcase
        end
    end

endmodule
